// File: rtl/ps2_packet_decoder.sv
// ---------------------------------------------------------------------------
// ps2_packet_decoder
//
// Assembles 3-byte (standard) or 4-byte (wheel) PS/2 mouse packets from the
// byte-level PS/2 receiver. It converts the 9-bit two's-complement deltas
// into scaled magnitude/direction velocities and reports the button state and
// button-press edges. It also resynchronises on bad headers and idle
// timeouts.
//
// Parameters:
//   PKT_BYTES - 3 (standard mouse) or 4 (wheel mouse)
//   VEL_SHIFT - right shift applied to each delta magnitude
//   VEL_W     - velocity output width (>= 9 - VEL_SHIFT)
//   TIMEOUT   - idle cycles before a partial packet / held velocity is dropped
//
// Ports:
//   clk        in   system clock, all logic on posedge
//   rst        in   synchronous active-high reset
//   byte_ready in   ready level from the byte receiver; a rising edge = new byte
//   byte_data  in   received byte, stable while byte_ready is high
//   pkt_valid  out  one-cycle pulse when a packet has been decoded
//   vx, vy     out  scaled delta magnitudes
//   dx, dy     out  direction, 1 = positive (X right, Y up)
//   btn        out  {middle, right, left} from the last packet
//   btn_press  out  rising-edge button flags, valid with pkt_valid
//   wheel      out  signed Z delta (0 for 3-byte packets)
//   ovf        out  {Y overflow, X overflow} from the last packet
//   sync_err   out  one-cycle pulse when a byte is rejected as a header
//   state      out  current FSM state (debug)
// ---------------------------------------------------------------------------
module ps2_packet_decoder #(
  parameter int PKT_BYTES = 3,
  parameter int VEL_SHIFT = 1,
  parameter int VEL_W     = 10,
  parameter int TIMEOUT   = 9999999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             byte_ready,
  input  logic [7:0]       byte_data,
  output logic             pkt_valid,
  output logic [VEL_W-1:0] vx,
  output logic [VEL_W-1:0] vy,
  output logic             dx,
  output logic             dy,
  output logic [2:0]       btn,
  output logic [2:0]       btn_press,
  output logic [3:0]       wheel,
  output logic [1:0]       ovf,
  output logic             sync_err,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_B0   = 3'd0,
    S_B1   = 3'd1,
    S_B2   = 3'd2,
    S_B3   = 3'd3,
    S_HOLD = 3'd4
  } state_t;

  localparam int               CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO   = CNT_W'(TIMEOUT);

  state_t           st;
  logic             rdy_q;
  logic [CNT_W-1:0] tmo_cnt;

  // Header fields kept individually; bit 3 is always 1 once accepted.
  logic [2:0]       hdr_btn;
  logic             hdr_sx, hdr_sy, hdr_ox, hdr_oy;
  logic [7:0]       xbyte, ybyte;

  assign state = st;

  // Magnitude of a 9-bit two's-complement delta. -256 maps to 256 because the
  // result is 9-bit unsigned. An overflowed axis saturates at 256.
  function automatic logic [8:0] axis_mag(input logic [8:0] val, input logic ov);
    if (ov)
      return 9'h100;
    return val[8] ? (~val + 9'd1) : val;
  endfunction

  logic       accept;
  logic       tmo_hit;
  logic       last_byte;
  logic [7:0] y_src;
  logic [3:0] z_src;
  logic [8:0] x_scaled, y_scaled;

  assign accept    = byte_ready & ~rdy_q;
  assign tmo_hit   = (tmo_cnt == TMO);
  assign last_byte = accept && ((st == S_B2 && PKT_BYTES == 3) || st == S_B3);

  // The closing byte is decoded straight off byte_data, so the results appear
  // in the cycle after it is accepted rather than one cycle later.
  assign y_src    = (PKT_BYTES == 4) ? ybyte : byte_data;
  assign z_src    = (PKT_BYTES == 4) ? byte_data[3:0] : 4'h0;
  assign x_scaled = axis_mag({hdr_sx, xbyte}, hdr_ox) >> VEL_SHIFT;
  assign y_scaled = axis_mag({hdr_sy, y_src}, hdr_oy) >> VEL_SHIFT;

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge values. Later assignments in the same block
  // deliberately override earlier defaults, such as the pulse clears and the
  // next-state choice.
  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= S_B0;
      rdy_q     <= 1'b0;
      tmo_cnt   <= '0;
      hdr_btn   <= '0;
      hdr_sx    <= 1'b0;
      hdr_sy    <= 1'b0;
      hdr_ox    <= 1'b0;
      hdr_oy    <= 1'b0;
      xbyte     <= '0;
      ybyte     <= '0;
      pkt_valid <= 1'b0;
      vx        <= '0;
      vy        <= '0;
      dx        <= 1'b0;
      dy        <= 1'b0;
      btn       <= '0;
      btn_press <= '0;
      wheel     <= '0;
      ovf       <= '0;
      sync_err  <= 1'b0;
    end else begin
      rdy_q     <= byte_ready;
      pkt_valid <= 1'b0;
      sync_err  <= 1'b0;

      if (accept)
        tmo_cnt <= '0;
      else if (!tmo_hit)
        tmo_cnt <= tmo_cnt + 1'b1;

      if (accept) begin
        // An accepted byte always wins over a timeout reached in the same cycle.
        unique case (st)
          S_B0, S_HOLD: begin
            if (byte_data[3]) begin
              hdr_btn <= byte_data[2:0];
              hdr_sx  <= byte_data[4];
              hdr_sy  <= byte_data[5];
              hdr_ox  <= byte_data[6];
              hdr_oy  <= byte_data[7];
              st      <= S_B1;
            end else begin
              sync_err <= 1'b1;
              st       <= S_B0;
            end
          end
          S_B1: begin
            xbyte <= byte_data;
            st    <= S_B2;
          end
          S_B2: begin
            ybyte <= byte_data;
            st    <= (PKT_BYTES == 4) ? S_B3 : S_HOLD;
          end
          S_B3:    st <= S_HOLD;
          default: st <= S_B0;
        endcase
      end else if (tmo_hit && st != S_B0) begin
        // Idle too long: drop a partial packet, or stop a held motion.
        if (st == S_HOLD) begin
          vx    <= '0;
          vy    <= '0;
          wheel <= '0;
        end
        st <= S_B0;
      end

      if (last_byte) begin
        pkt_valid <= 1'b1;
        vx        <= VEL_W'(x_scaled);
        vy        <= VEL_W'(y_scaled);
        dx        <= ~hdr_sx;
        dy        <= ~hdr_sy;
        btn       <= hdr_btn;
        // btn only changes on a decoded packet, so it is the previous packet's
        // button state at this point.
        btn_press <= hdr_btn & ~btn;
        wheel     <= z_src;
        ovf       <= {hdr_oy, hdr_ox};
      end
    end
  end

endmodule

// File: tb/tb_ps2_packet_decoder.sv
// ---------------------------------------------------------------------------
// tb_ps2_packet_decoder
//
// Self-checking bench for ps2_packet_decoder. A 3-byte instance and a 4-byte
// wheel instance both run with TIMEOUT=100. Packets come from a table of
// vectors with hand-computed expectations. Hand-written sequences cover
// header resync, the partial-packet timeout, the hold timeout, byte_ready
// held high and reset mid-packet.
// ---------------------------------------------------------------------------
module tb_ps2_packet_decoder;

  localparam int TMO = 100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       rdy3, rdy4;
  logic [7:0] d3, d4;

  logic       pv3, pv4, dx3, dx4, dy3, dy4, se3, se4;
  logic [9:0] vx3, vx4, vy3, vy4;
  logic [2:0] btn3, btn4, bp3, bp4, st3, st4;
  logic [3:0] wh3, wh4;
  logic [1:0] ovf3, ovf4;

  ps2_packet_decoder #(.PKT_BYTES(3), .VEL_SHIFT(1), .VEL_W(10), .TIMEOUT(TMO)) dut3 (
    .clk(clk), .rst(rst), .byte_ready(rdy3), .byte_data(d3),
    .pkt_valid(pv3), .vx(vx3), .vy(vy3), .dx(dx3), .dy(dy3),
    .btn(btn3), .btn_press(bp3), .wheel(wh3), .ovf(ovf3),
    .sync_err(se3), .state(st3)
  );

  ps2_packet_decoder #(.PKT_BYTES(4), .VEL_SHIFT(1), .VEL_W(10), .TIMEOUT(TMO)) dut4 (
    .clk(clk), .rst(rst), .byte_ready(rdy4), .byte_data(d4),
    .pkt_valid(pv4), .vx(vx4), .vy(vy4), .dx(dx4), .dy(dy4),
    .btn(btn4), .btn_press(bp4), .wheel(wh4), .ovf(ovf4),
    .sync_err(se4), .state(st4)
  );

  // sel picks which instance the stimulus and checks refer to.
  bit         sel;
  logic       o_pv, o_dx, o_dy, o_se;
  logic [9:0] o_vx, o_vy;
  logic [2:0] o_btn, o_bp, o_st;
  logic [3:0] o_wh;
  logic [1:0] o_ovf;

  assign o_pv  = sel ? pv4  : pv3;
  assign o_vx  = sel ? vx4  : vx3;
  assign o_vy  = sel ? vy4  : vy3;
  assign o_dx  = sel ? dx4  : dx3;
  assign o_dy  = sel ? dy4  : dy3;
  assign o_btn = sel ? btn4 : btn3;
  assign o_bp  = sel ? bp4  : bp3;
  assign o_wh  = sel ? wh4  : wh3;
  assign o_ovf = sel ? ovf4 : ovf3;
  assign o_se  = sel ? se4  : se3;
  assign o_st  = sel ? st4  : st3;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One accepted byte: ready high for one cycle, then low (maximum byte rate).
  // Returns on the negedge after the accepting posedge.
  task automatic send(input logic [7:0] d);
    @(negedge clk);
    if (sel) begin rdy4 = 1'b1; d4 = d; end
    else     begin rdy3 = 1'b1; d3 = d; end
    @(negedge clk);
    rdy3 = 1'b0;
    rdy4 = 1'b0;
  endtask

  typedef struct {
    bit         dut4;
    int         n;
    logic [31:0] pkt;    // first byte in the MSBs
    logic [9:0] vx, vy;
    logic       dx, dy;
    logic [2:0] btn, bp;
    logic [1:0] ovf;
    logic [3:0] wheel;
  } vec_t;

  vec_t tv[9];

  task automatic run_vec(input int i);
    sel = tv[i].dut4;
    for (int j = 0; j < tv[i].n; j++) begin
      send(tv[i].pkt[31 - 8*j -: 8]);
      if (j < tv[i].n - 1)
        check($sformatf("v%0d early pkt_valid b%0d", i, j), o_pv, 1'b0);
    end
    check($sformatf("v%0d pkt_valid", i), o_pv,  1'b1);
    check($sformatf("v%0d vx", i),        o_vx,  tv[i].vx);
    check($sformatf("v%0d vy", i),        o_vy,  tv[i].vy);
    check($sformatf("v%0d dx", i),        o_dx,  tv[i].dx);
    check($sformatf("v%0d dy", i),        o_dy,  tv[i].dy);
    check($sformatf("v%0d btn", i),       o_btn, tv[i].btn);
    check($sformatf("v%0d btn_press", i), o_bp,  tv[i].bp);
    check($sformatf("v%0d ovf", i),       o_ovf, tv[i].ovf);
    check($sformatf("v%0d wheel", i),     o_wh,  tv[i].wheel);
    check($sformatf("v%0d state", i),     o_st,  3'd4);
    @(negedge clk);
    check($sformatf("v%0d pkt_valid n+2", i), o_pv, 1'b0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " pkt_valid"}, o_pv,  1'b0);
    check({tag, " vx"},        o_vx,  10'd0);
    check({tag, " vy"},        o_vy,  10'd0);
    check({tag, " dxdy"},      {o_dx, o_dy}, 2'b00);
    check({tag, " btn"},       o_btn, 3'b000);
    check({tag, " btn_press"}, o_bp,  3'b000);
    check({tag, " wheel"},     o_wh,  4'h0);
    check({tag, " ovf"},       o_ovf, 2'b00);
    check({tag, " sync_err"},  o_se,  1'b0);
    check({tag, " state"},     o_st,  3'd0);
  endtask

  initial begin
    bit pv_seen;

    //          dut4 n  bytes          vx      vy      dx dy btn     press   ovf    wheel
    tv[0] = '{1'b0, 3, 32'h2905FA00, 10'd2,   10'd3,   1, 0, 3'b001, 3'b001, 2'b00, 4'h0};
    tv[1] = '{1'b0, 3, 32'h08100000, 10'd8,   10'd0,   1, 1, 3'b000, 3'b000, 2'b00, 4'h0};
    tv[2] = '{1'b0, 3, 32'h09020200, 10'd1,   10'd1,   1, 1, 3'b001, 3'b001, 2'b00, 4'h0};
    tv[3] = '{1'b0, 3, 32'h58000000, 10'd128, 10'd0,   0, 1, 3'b000, 3'b000, 2'b01, 4'h0};
    tv[4] = '{1'b0, 3, 32'h28000000, 10'd0,   10'd128, 1, 0, 3'b000, 3'b000, 2'b00, 4'h0};
    tv[5] = '{1'b0, 3, 32'h1B807F00, 10'd64,  10'd63,  0, 1, 3'b011, 3'b011, 2'b00, 4'h0};
    tv[6] = '{1'b1, 4, 32'h0A01010F, 10'd0,   10'd0,   1, 1, 3'b010, 3'b010, 2'b00, 4'hF};
    tv[7] = '{1'b1, 4, 32'h0A01010F, 10'd0,   10'd0,   1, 1, 3'b010, 3'b000, 2'b00, 4'hF};
    tv[8] = '{1'b0, 3, 32'h09020200, 10'd1,   10'd1,   1, 1, 3'b001, 3'b001, 2'b00, 4'h0};

    rst  = 1'b1;
    rdy3 = 1'b0;
    rdy4 = 1'b0;
    d3   = 8'h00;
    d4   = 8'h00;
    sel  = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("rst3");
    sel = 1'b1;
    #1;
    check_reset_state("rst4");
    rst = 1'b0;

    // Basic decode.
    run_vec(0);

    // A non-header byte in S_HOLD pulses sync_err and returns to S_B0.
    sel = 1'b0;
    send(8'h00);
    check("resync sync_err", o_se, 1'b1);
    check("resync state",    o_st, 3'd0);
    @(negedge clk);
    check("resync sync_err off", o_se, 1'b0);
    run_vec(1);

    // A partial packet is dropped after TIMEOUT idle cycles, silently.
    send(8'h08);
    send(8'h10);
    check("partial state B2", o_st, 3'd2);
    pv_seen = 1'b0;
    repeat (TMO + 10) begin
      @(negedge clk);
      if (o_pv) pv_seen = 1'b1;
    end
    check("partial no pkt_valid", pv_seen, 1'b0);
    check("partial state B0",     o_st,    3'd0);
    check("partial vx held",      o_vx,    10'd8);
    run_vec(2);

    // Overflow, minimum negative, larger deltas, then the wheel packets.
    for (int i = 3; i < 8; i++)
      run_vec(i);

    // Hold timeout: velocities and wheel clear, buttons and direction stay.
    repeat (TMO + 10) @(negedge clk);
    sel = 1'b0;
    #1;
    check("hold3 vx",    o_vx,  10'd0);
    check("hold3 vy",    o_vy,  10'd0);
    check("hold3 btn",   o_btn, 3'b011);
    check("hold3 dxdy",  {o_dx, o_dy}, 2'b01);
    check("hold3 state", o_st,  3'd0);
    sel = 1'b1;
    #1;
    check("hold4 wheel", o_wh,  4'h0);
    check("hold4 btn",   o_btn, 3'b010);
    check("hold4 state", o_st,  3'd0);

    // byte_ready held high for several cycles yields exactly one accept.
    sel = 1'b0;
    @(negedge clk);
    rdy3 = 1'b1;
    d3   = 8'h08;
    repeat (6) @(negedge clk);
    rdy3 = 1'b0;
    check("held ready state B1", o_st, 3'd1);
    send(8'h10);
    check("midrst state B2", o_st, 3'd2);

    // Reset mid-packet discards it; the next packet decodes normally.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_state("midrst");
    rst = 1'b0;
    run_vec(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_packet_decoder.md
# ps2_packet_decoder

Parametrised PS/2 mouse packet decoder. It assembles 3- or 4-byte mouse packets from the byte-level PS/2 receiver and resynchronises on framing errors or timeouts. It converts the 9-bit two's-complement deltas into scaled magnitude/direction velocities and reports button state and button-press edges. It sits between the PS/2 byte receiver and the cursor motion logic, replacing the hand-written packet FSM in the top level.

## Interface
Parameters:
- PKT_BYTES, 3: bytes per packet; 3 = standard mouse, 4 = wheel mouse. No other values are legal.
- VEL_SHIFT, 1: right-shift applied to the delta magnitude.
- VEL_W, 10: velocity output width; must be ≥ 9 − VEL_SHIFT.
- TIMEOUT, 9999999: idle cycles allowed before a partial packet is dropped or held velocity is cleared.

Ports:
- clk, in, 1: system clock. There is one clock domain; all logic is on posedge clk.
- rst, in, 1: reset, synchronous and active-high.
- byte_ready, in, 1: ready level from the PS/2 byte receiver. A rising edge marks a new byte.
- byte_data, in, 8: received byte, stable while byte_ready is high.
- pkt_valid, out, 1: one-cycle pulse when a packet is decoded.
- vx, vy, out, VEL_W: scaled delta magnitudes.
- dx, dy, out, 1: direction; 1 = positive (X right, Y up).
- btn, out, 3: {middle, right, left} from the last packet.
- btn_press, out, 3: one-cycle rising-edge flags, valid with pkt_valid.
- wheel, out, 4: signed Z delta; constant 0 when PKT_BYTES=3.
- ovf, out, 2: {Y overflow, X overflow} from the last packet.
- sync_err, out, 1: one-cycle pulse when a byte is rejected as a header.
- state, out, 3: current FSM state (debug).

## Operation
- **Edge detect:** a register rdy_q holds the previous byte_ready. A byte is accepted in the cycle where byte_ready & ~rdy_q, and byte_data is captured in that same cycle.
- **FSM states:** S_B0, S_B1, S_B2, S_B3 (used only if PKT_BYTES=4), S_HOLD.
  - S_B0: an accepted byte with bit3=1 is latched as the header, then go to S_B1. An accepted byte with bit3=0 pulses sync_err and stays in S_B0.
  - S_B1: the accepted byte is latched as X, then go to S_B2.
  - S_B2: the accepted byte is latched as Y. Go to S_B3 if PKT_BYTES=4, otherwise decode and go to S_HOLD.
  - S_B3: the accepted byte is latched as Z, then decode and go to S_HOLD.
  - S_HOLD: behaves as S_B0 for header acceptance, except a rejected byte returns to S_B0. Outputs are held.
- **Sign and overflow:** X = {hdr[4], xbyte} and Y = {hdr[5], ybyte}, both 9-bit two's complement. ovf = {hdr[7], hdr[6]}.
- **Magnitude:** mag = sign ? −val : val, giving 0..256.
  - If the axis overflow bit is set, mag = 256 and the direction keeps the header sign.
  - v = mag >> VEL_SHIFT, zero-extended to VEL_W.
  - dx = ~hdr[4]; dy = ~hdr[5].
- **Buttons:** btn = hdr[2:0]. btn_press = hdr[2:0] & ~btn_prev, where btn_prev is the btn value from the previous packet.
- **Wheel:** wheel = zbyte[3:0].
- **Timeout counter:**
  - Cleared on every accepted byte; increments otherwise and saturates at TIMEOUT.
  - On reaching TIMEOUT in S_B1, S_B2 or S_B3, the partial packet is discarded and the FSM goes to S_B0. No pulse is generated.
  - On reaching TIMEOUT in S_HOLD, vx, vy and wheel are cleared to 0 and the FSM goes to S_B0. btn, dx, dy and ovf are held.

## Timing
- **Reset values:** every output is 0, except state = S_B0. rdy_q, btn_prev and the timeout counter are also 0.
- **Latency:** the final byte is accepted in cycle n. In cycle n+1, pkt_valid=1 and btn_press is valid, and vx, vy, dx, dy, btn, wheel and ovf hold the new values. pkt_valid is low at n+2.
- **sync_err:** pulses in cycle n+1 after the rejected byte is accepted in cycle n.
- **Byte rate:** back-to-back accepted bytes are legal at one per 2 cycles. byte_ready held high produces exactly one accept.
- **Simultaneous events:** if a byte is accepted in the same cycle the timeout is reached, the byte wins; it is processed and the counter clears.
- **Reset mid-packet:** asserting rst during a partial packet discards it. The next packet decodes normally.
- **Packet boundary:** a new header accepted in S_HOLD starts the next packet. Outputs keep their old values until that packet's pkt_valid.

## Test plan
- **Basic decode:** PKT_BYTES=3, VEL_SHIFT=1; send bytes 0x29, 0x05, 0xFA → single pkt_valid; vx=2, dx=1, vy=3, dy=0, btn=001, btn_press=001, ovf=00.
- **Header resync:** send 0x00 → sync_err pulse, state=S_B0; then 0x08, 0x10, 0x00 → vx=8, dx=1, vy=0, btn=000, btn_press=000.
- **Partial-packet timeout:** TIMEOUT=100; send 0x08, 0x10, then idle 100 cycles → state=S_B0, no pkt_valid; then 0x09, 0x02, 0x02 → vx=1, vy=1, btn_press=001.
- **Overflow and minimum negative:** send 0x58, 0x00, 0x00 → ovf=01, vx=128, dx=0, vy=0. Then send 0x28, 0x00, 0x00 → vy=128, dy=0.
- **Wheel packet:** PKT_BYTES=4; send 0x0A, 0x01, 0x01, 0x0F → pkt_valid only after the 4th byte; wheel=4'hF (−1), btn=010, btn_press=010. Repeat the same packet → btn_press=000.
- **Hold clear and reset:** after a decoded packet, idle TIMEOUT cycles → vx=vy=0, btn held. Separately, assert rst after 2 of 3 bytes → all outputs 0; the next full packet decodes correctly.
